dbuf2ddr: RTL

DBUF2DDR -- requirements
Module: dbuf2ddr

---
 rtl/dbuf2ddr.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/dbuf2ddr.sv
// Streams dbuf bank contents to DDR: a read sequencer walks the CONV (row/pix/ch)
// or FC (ch) order, and the returned lanes pass through a 4-entry FIFO to the DDR port.
module dbuf2ddr #(
  parameter int BUF_DEPTH = 256,
  parameter int ADDR_W    = $clog2(BUF_DEPTH),
  parameter int DATA_W    = 16,
  parameter int BATCH     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         done,
  input  logic [2:0]                   conf_mode,
  input  logic [3:0]                   conf_ch_num,
  input  logic [3:0]                   conf_row_num,
  input  logic [3:0]                   conf_pix_num,
  output logic [ADDR_W-1:0]            dbuf_rd_addr,
  output logic [3:0]                   dbuf_rd_en,
  input  logic [3:0][DATA_W*BATCH-1:0] dbuf_rd_data,
  output logic [DATA_W*BATCH-1:0]      ddr_data,
  output logic                         ddr_valid,
  input  logic                         ddr_ready,
  output logic [1:0]                   dbg_state
);

  localparam int LANE_W = DATA_W * BATCH;
  localparam int DDR_W  = LANE_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0] state_q, state_d;

  // Job configuration captured at launch
  logic       mode_fc_q;
  logic [3:0] ch_max_q, row_max_q, pix_max_q;

  // Read-order counters
  logic [3:0] ch_q, row_q, pix_q;

  // Read pipeline: dbuf returns data exactly one cycle after the enable
  logic       rd_vld_q;
  logic [1:0] rd_bank_q;

  // Output FIFO
  logic [DDR_W-1:0] fifo_mem [4];
  logic [1:0]       wr_ptr_q, rd_ptr_q;
  logic [2:0]       fifo_cnt_q, fifo_cnt_d;

  logic       credit_ok;
  logic       issue;
  logic       last_rd;
  logic [1:0] rd_bank;
  logic [7:0] rd_addr8;
  logic       push, pop;

  logic unused_conf_mode;
  assign unused_conf_mode = ^conf_mode[2:1];

  // Credit covers both buffered beats and the read whose data is still on its way,
  // so the FIFO can never be pushed while full.
  assign credit_ok = (fifo_cnt_q + {2'b00, rd_vld_q}) <= 3'd3;
  assign issue     = (state_q == S_RUN) && credit_ok && !rst;

  assign last_rd = (ch_q == ch_max_q) &&
                   (mode_fc_q || ((pix_q == pix_max_q) && (row_q == row_max_q)));

  always_comb begin
    rd_bank  = 2'd0;
    rd_addr8 = {4'd0, ch_q};
    if (!mode_fc_q) begin
      rd_bank  = {row_q[0], pix_q[0]};
      rd_addr8 = {ch_q, row_q[1], pix_q[3:1]};
    end
  end

  assign dbuf_rd_addr = ADDR_W'(rd_addr8);
  assign dbuf_rd_en   = issue ? (4'b0001 << rd_bank) : 4'b0000;

  // DDR handshake: ddr_valid is high whenever a beat is buffered, ddr_data is the
  // FIFO head and stays put until the beat is taken on a cycle with ddr_valid && ddr_ready.
  assign push      = rd_vld_q;
  assign ddr_valid = (fifo_cnt_q != 3'd0);
  assign pop       = ddr_valid && ddr_ready;
  assign ddr_data  = fifo_mem[rd_ptr_q];

  assign done      = (state_q == S_IDLE);
  assign dbg_state = state_q;

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (issue && last_rd) state_d = S_DRAIN;
      // Leave on the edge that empties the FIFO so done rises right after the last beat
      S_DRAIN: if ((fifo_cnt_d == 3'd0) && !rd_vld_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_fc_q  <= 1'b0;
      ch_max_q   <= 4'd0;
      row_max_q  <= 4'd0;
      pix_max_q  <= 4'd0;
      ch_q       <= 4'd0;
      row_q      <= 4'd0;
      pix_q      <= 4'd0;
      rd_vld_q   <= 1'b0;
      rd_bank_q  <= 2'd0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      fifo_cnt_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      rd_vld_q   <= issue;
      rd_bank_q  <= rd_bank;
      fifo_cnt_q <= fifo_cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;

      if ((state_q == S_IDLE) && start) begin
        mode_fc_q <= conf_mode[0];
        ch_max_q  <= conf_ch_num;
        row_max_q <= conf_row_num;
        pix_max_q <= conf_pix_num;
        ch_q      <= 4'd0;
        row_q     <= 4'd0;
        pix_q     <= 4'd0;
      end else if (issue) begin
        // ch innermost, then pix, then row; everything returns to 0 after the last read
        if (ch_q != ch_max_q) begin
          ch_q <= ch_q + 4'd1;
        end else begin
          ch_q <= 4'd0;
          if (!mode_fc_q) begin
            if (pix_q != pix_max_q) begin
              pix_q <= pix_q + 4'd1;
            end else begin
              pix_q <= 4'd0;
              if (row_q != row_max_q) row_q <= row_q + 4'd1;
              else                    row_q <= 4'd0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= dbuf_rd_data[rd_bank_q];
  end

endmodule
